// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared MNIST pipeline widths and classifier FSM encoding
package mnist_pkg;

    localparam int DATA_W      = 32;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    // One extra bit so the count can reach NUM_CLASSES even when it equals 2**IDX_W.
    localparam int CNT_W       = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - serial argmax over layer-2 scores, held one-hot digit for LEDR
module argmax_classifier
    import mnist_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   score_valid,
    input  logic [DATA_W-1:0]      score_value,
    output logic                   score_ready,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       class_idx,
    output logic [DATA_W-1:0]      max_score,
    output logic [NUM_CLASSES-1:0] led_onehot
);

    localparam logic [NUM_CLASSES-1:0] LED_ONE   = NUM_CLASSES'(1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(NUM_CLASSES);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_count;
    logic signed [DATA_W-1:0] r_best_val;
    logic [IDX_W-1:0]         r_best_idx;
    logic                     r_result_valid;
    logic [IDX_W-1:0]         r_class_idx;
    logic [DATA_W-1:0]        r_max_score;
    logic [NUM_CLASSES-1:0]   r_led_onehot;

    logic                     w_xfer;
    logic                     w_last;
    logic [CNT_W-1:0]         w_count_next;
    logic signed [DATA_W-1:0] w_cand_val;
    logic [IDX_W-1:0]         w_cand_idx;

    assign score_ready  = (r_state != ST_DONE) && !clear;
    assign w_xfer       = score_valid && score_ready;
    assign busy         = (r_state == ST_SCAN);
    assign result_valid = r_result_valid;
    assign class_idx    = r_class_idx;
    assign max_score    = r_max_score;
    assign led_onehot   = r_led_onehot;

    // Candidate best after the score on the input; strict > keeps the lowest index on ties.
    always_comb begin
        w_cand_val   = r_best_val;
        w_cand_idx   = r_best_idx;
        w_count_next = r_count + CNT_W'(1);
        if (r_state == ST_IDLE) begin
            w_cand_val   = $signed(score_value);
            w_cand_idx   = '0;
            w_count_next = CNT_W'(1);
        end else if ($signed(score_value) > r_best_val) begin
            w_cand_val = $signed(score_value);
            w_cand_idx = r_count[IDX_W-1:0];
        end
    end

    assign w_last = (w_count_next == CNT_LAST);

    // Outputs load on the final transfer so they are already valid during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_best_val     <= '0;
            r_best_idx     <= '0;
            r_result_valid <= 1'b0;
            r_class_idx    <= '0;
            r_max_score    <= '0;
            r_led_onehot   <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SCAN: begin
                    if (clear) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_best_val <= w_cand_val;
                        r_best_idx <= w_cand_idx;
                        r_count    <= w_count_next;
                        if (w_last) begin
                            r_state        <= ST_DONE;
                            r_result_valid <= 1'b1;
                            r_class_idx    <= w_cand_idx;
                            r_max_score    <= w_cand_val;
                            r_led_onehot   <= LED_ONE << w_cand_idx;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - self-checking bench for argmax_classifier against an array argmax model
module tb_argmax_classifier;
    import mnist_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clear;
    logic                   score_valid;
    logic [DATA_W-1:0]      score_value;
    logic                   score_ready;
    logic                   busy;
    logic                   result_valid;
    logic [IDX_W-1:0]       class_idx;
    logic [DATA_W-1:0]      max_score;
    logic [NUM_CLASSES-1:0] led_onehot;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bad_rdy  = 0;
    int last_xfer;

    typedef struct {
        int                     idx;
        int                     val;
        logic [NUM_CLASSES-1:0] led;
        int                     c;
        logic                   rdy;
    } res_t;
    res_t res_q[$];

    argmax_classifier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .score_valid  (score_valid),
        .score_value  (score_value),
        .score_ready  (score_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .led_onehot   (led_onehot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every published result; ready must be low exactly when clear is high or a result is out.
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid) begin
                res_q.push_back('{idx: int'(class_idx), val: int'(max_score),
                                  led: led_onehot, c: cyc, rdy: score_ready});
            end
            if (score_ready == (result_valid || clear)) bad_rdy <= bad_rdy + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_argmax(input int s[NUM_CLASSES]);
        int b = 0;
        for (int i = 1; i < NUM_CLASSES; i++) if (s[i] > s[b]) b = i;
        return b;
    endfunction

    task automatic send_score(input int v, input int max_gap);
        int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bit done = 1'b0;
        score_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        score_valid = 1'b1;
        score_value = v;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (score_ready) begin
                last_xfer = cyc + 1;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_image(input int s[NUM_CLASSES], input int max_gap);
        for (int i = 0; i < NUM_CLASSES; i++) send_score(s[i], max_gap);
    endtask

    task automatic check_result(input string tag, input int s[NUM_CLASSES], input int xfer_cyc);
        int waited = 0;
        int e;
        res_t r;
        logic [NUM_CLASSES-1:0] one = NUM_CLASSES'(1);
        while (res_q.size() == 0 && waited < 10) begin @(posedge clk); #1; waited++; end
        if (res_q.size() == 0) begin
            chk({tag, "_no_result"}, 64'(res_q.size()), 64'd1);
        end else begin
            r = res_q.pop_front();
            e = ref_argmax(s);
            chk({tag, "_idx"}, 64'(r.idx), 64'(e));
            chk({tag, "_val"}, 64'(r.val), 64'(s[e]));
            chk({tag, "_led"}, 64'(r.led), 64'(one << e));
            chk({tag, "_latency"}, 64'(r.c), 64'(xfer_cyc));
            chk({tag, "_ready_in_done"}, 64'(r.rdy), 64'd0);
        end
    endtask

    initial begin
        int img[NUM_CLASSES];
        int img_b[NUM_CLASSES];
        int la;
        int lb;
        logic [IDX_W-1:0]       held_idx;
        logic [DATA_W-1:0]      held_val;
        logic [NUM_CLASSES-1:0] held_led;

        rst_n = 1'b0; clear = 1'b0; score_valid = 1'b0; score_value = '0;
        #2;
        chk("rst_ready", 64'(score_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_idx", 64'(class_idx), 64'd0);
        chk("rst_max", 64'(max_score), 64'd0);
        chk("rst_led", 64'(led_onehot), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        img = '{5, -3, 9, 0, 2, 9, 1, -7, 4, 8};
        send_image(img, 0);
        check_result("t2", img, last_xfer);
        chk("t2_held_idx", 64'(class_idx), 64'd2);
        chk("t2_held_max", 64'(max_score), 64'd9);
        chk("t2_held_led", 64'(led_onehot), 64'b0000000100);

        for (int i = 0; i < NUM_CLASSES; i++) img[i] = 32'h8000_0000;
        send_image(img, 3);
        check_result("t3", img, last_xfer);
        chk("t3_held_max", 64'(max_score), 64'h0000_0000_8000_0000);

        for (int i = 0; i < NUM_CLASSES; i++) img[i] = i;
        img_b[0] = 50;
        for (int i = 1; i < NUM_CLASSES; i++) img_b[i] = int'($urandom_range(149, 0)) - 100;
        send_image(img, 0);
        la = last_xfer;
        send_image(img_b, 0);
        lb = last_xfer;
        check_result("t4a", img, la);
        check_result("t4b", img_b, lb);
        chk("t4_ready_only_in_done", 64'(bad_rdy), 64'd0);

        held_idx = class_idx; held_val = max_score; held_led = led_onehot;
        for (int i = 0; i < 4; i++) send_score(int'($urandom), 1);
        chk("t5_busy_partial", 64'(busy), 64'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t5_busy_after_clear", 64'(busy), 64'd0);
        chk("t5_held_idx", 64'(class_idx), 64'(held_idx));
        chk("t5_held_max", 64'(max_score), 64'(held_val));
        chk("t5_held_led", 64'(led_onehot), 64'(held_led));
        chk("t5_no_result", 64'(res_q.size()), 64'd0);
        for (int i = 0; i < NUM_CLASSES; i++) img[i] = int'($urandom_range(999, 0)) - 500;
        img[7] = 1000;
        send_image(img, 2);
        check_result("t5", img, last_xfer);
        chk("t5_class7", 64'(class_idx), 64'd7);

        clear = 1'b1; score_valid = 1'b1; score_value = 32'd12345;
        @(negedge clk);
        chk("t6_ready_during_clear", 64'(score_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; score_valid = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NUM_CLASSES; i++) img[i] = int'($urandom_range(20, 0)) - 10;
        send_image(img, 1);
        check_result("t6", img, last_xfer);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                img[i] = (k % 2 == 0) ? int'($urandom) : int'($urandom_range(3, 0)) - 2;
            send_image(img, 2);
            check_result($sformatf("rnd%0d", k), img, last_xfer);
        end

        for (int i = 0; i < 3; i++) send_score(int'($urandom), 0);
        rst_n = 1'b0;
        #1;
        chk("t1_mid_ready", 64'(score_ready), 64'd1);
        chk("t1_mid_busy", 64'(busy), 64'd0);
        chk("t1_mid_rv", 64'(result_valid), 64'd0);
        chk("t1_mid_idx", 64'(class_idx), 64'd0);
        chk("t1_mid_max", 64'(max_score), 64'd0);
        chk("t1_mid_led", 64'(led_onehot), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CLASSES; i++) img[i] = int'($urandom);
        send_image(img, 0);
        check_result("post_rst", img, last_xfer);

        repeat (3) @(posedge clk);
        #1;
        chk("no_extra_results", 64'(res_q.size()), 64'd0);
        chk("ready_invariant", 64'(bad_rdy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
